// File: rtl/fp_pkg.sv
// Shared floating-point constants: standard field widths, flag bit positions,
// buffer occupancy encoding and the quiet-NaN mantissa pattern.
package fp_pkg;

   localparam int SP_EXP_W = 8;
   localparam int SP_MAN_W = 23;
   localparam int DP_EXP_W = 11;
   localparam int DP_MAN_W = 52;

   localparam int FLG_INV = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_UNF = 0;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   // Quiet NaN carries only the mantissa MSB; returns the pattern bit at idx.
   function automatic logic qnan_man_bit(input int idx, input int man_w);
      qnan_man_bit = (idx == man_w - 1) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/fp_result_packer_if.sv
// Upstream/downstream valid-ready bundle of the result packer.
// The slave modport is the packer side; the master modport drives it.
interface fp_result_packer_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_sign;
   logic [EXP_W-1:0]       in_exp;
   logic [MAN_W-1:0]       in_man;
   logic                   in_overflow;
   logic                   in_underflow;
   logic                   in_invalid;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_W+MAN_W:0]   out_result;
   logic [2:0]             out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_man, in_overflow, in_underflow, in_invalid,
      output out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_man, in_overflow, in_underflow, in_invalid,
      input  out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_skid_buffer.sv
// Generic-width two-entry valid/ready buffer (main output register plus skid register).
// in_ready is registered so it never depends combinationally on out_ready.
module fp_skid_buffer
   import fp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   buf_state_e   state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         push_s;
   logic         pop_s;

   // Occupancy next-state and data movement between input, skid and main.
   always_comb begin
      push_s  = in_valid_i && in_ready_q;
      pop_s   = out_valid_q && out_ready_i;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         BUF_EMPTY: begin
            if (push_s) begin
               state_d = BUF_ONE;
               main_d  = in_data_i;
            end else begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_ONE: begin
            if (push_s && !pop_s) begin
               state_d = BUF_FULL;
               skid_d  = in_data_i;
            end else if (push_s && pop_s) begin
               main_d  = in_data_i;
            end else if (pop_s) begin
               state_d = BUF_EMPTY;
            end else begin
               state_d = BUF_ONE;
            end
         end
         BUF_FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (pop_s) begin
               state_d = BUF_ONE;
               main_d  = skid_q;
            end else begin
               state_d = BUF_FULL;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
         end
      endcase
      in_ready_d  = (state_d != BUF_FULL);
      out_valid_d = (state_d != BUF_EMPTY);
   end

   // State, data and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BUF_EMPTY;
         main_q      <= {W{1'b0}};
         skid_q      <= {W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = main_q;

endmodule

// File: rtl/fp_result_packer.sv
// Final FP stage: resolves NaN/inf/zero, packs {sign, exp, man} and buffers it.
// Optional FP_STICKY_FLAGS_EN adds flags_clr and an accumulating sticky_flags register.
module fp_result_packer
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   fp_result_packer_if.slave bus
`ifdef FP_STICKY_FLAGS_EN
   ,
   input  logic              flags_clr,
   output logic [2:0]        sticky_flags
`endif
);

   localparam int RES_W  = 1 + EXP_W + MAN_W;
   localparam int DATA_W = RES_W + 3;

   logic [MAN_W-1:0]  qnan_man_s;
   logic [RES_W-1:0]  res_s;
   logic [2:0]        flags_s;
   logic [DATA_W-1:0] out_data_s;

   // Special-value priority: invalid, then overflow, then underflow.
   always_comb begin
      for (int i = 0; i < MAN_W; i++) begin
         qnan_man_s[i] = qnan_man_bit(i, MAN_W);
      end
      flags_s          = 3'b000;
      flags_s[FLG_INV] = bus.in_invalid;
      flags_s[FLG_OVF] = bus.in_overflow;
      flags_s[FLG_UNF] = bus.in_underflow;
      if (bus.in_invalid) begin
         res_s = {1'b0, {EXP_W{1'b1}}, qnan_man_s};
      end else if (bus.in_overflow) begin
         res_s = {bus.in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (bus.in_underflow) begin
         res_s = {bus.in_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      end else begin
         res_s = {bus.in_sign, bus.in_exp, bus.in_man};
      end
   end

   fp_skid_buffer #(
      .W (DATA_W)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (bus.in_ready),
      .in_data_i   ({flags_s, res_s}),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (out_data_s)
   );

   assign bus.out_result = out_data_s[RES_W-1:0];
   assign bus.out_flags  = out_data_s[DATA_W-1:RES_W];

`ifdef FP_STICKY_FLAGS_EN
   logic [2:0] sticky_q, sticky_d;

   // A clear drops the old flags but keeps those of a coincident transfer.
   always_comb begin
      sticky_d = flags_clr ? 3'b000 : sticky_q;
      if (bus.out_valid && bus.out_ready) begin
         sticky_d = sticky_d | bus.out_flags;
      end else begin
         sticky_d = sticky_d | 3'b000;
      end
   end

   // Sticky flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 3'b000;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed, table-driven bench for fp_result_packer at single and double precision.
module tb_fp_result_packer;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
      logic        ovf;
      logic        unf;
      logic        inv;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs [9];
   vec_t va, vb, vc;

   always #5 clk = ~clk;

   fp_result_packer_if #(.EXP_W(8),  .MAN_W(23)) sp_if ();
   fp_result_packer_if #(.EXP_W(11), .MAN_W(52)) dp_if ();

`ifdef FP_STICKY_FLAGS_EN
   logic       sp_clr = 1'b0;
   logic       dp_clr = 1'b0;
   logic [2:0] sp_sticky;
   logic [2:0] dp_sticky;
`endif

   fp_result_packer #(.EXP_W(8), .MAN_W(23)) u_sp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sp_if)
`ifdef FP_STICKY_FLAGS_EN
      ,
      .flags_clr    (sp_clr),
      .sticky_flags (sp_sticky)
`endif
   );

   fp_result_packer #(.EXP_W(11), .MAN_W(52)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dp_if)
`ifdef FP_STICKY_FLAGS_EN
      ,
      .flags_clr    (dp_clr),
      .sticky_flags (dp_sticky)
`endif
   );

   function automatic vec_t mkv(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic o, input logic u, input logic i,
                                input logic [31:0] r, input logic [2:0] f);
      vec_t v;
      v.sign = s; v.exp = e; v.man = m; v.ovf = o; v.unf = u; v.inv = i;
      v.res = r;  v.flg = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sp(input vec_t v, input logic valid);
      sp_if.in_valid     = valid;
      sp_if.in_sign      = v.sign;
      sp_if.in_exp       = v.exp;
      sp_if.in_man       = v.man;
      sp_if.in_overflow  = v.ovf;
      sp_if.in_underflow = v.unf;
      sp_if.in_invalid   = v.inv;
   endtask

   task automatic drive_dp(input logic s, input logic [10:0] e, input logic [51:0] m,
                           input logic o, input logic u, input logic i, input logic valid);
      dp_if.in_valid     = valid;
      dp_if.in_sign      = s;
      dp_if.in_exp       = e;
      dp_if.in_man       = m;
      dp_if.in_overflow  = o;
      dp_if.in_underflow = u;
      dp_if.in_invalid   = i;
   endtask

   initial begin
      vecs[0] = mkv(1'b1, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0, 32'hC0400000, 3'b000);
      vecs[1] = mkv(1'b0, 8'h12, 23'h000000, 1'b1, 1'b0, 1'b0, 32'h7F800000, 3'b010);
      vecs[2] = mkv(1'b1, 8'h12, 23'h000000, 1'b1, 1'b0, 1'b0, 32'hFF800000, 3'b010);
      vecs[3] = mkv(1'b1, 8'h33, 23'h123456, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 3'b110);
      vecs[4] = mkv(1'b1, 8'h05, 23'h000777, 1'b0, 1'b1, 1'b0, 32'h80000000, 3'b001);
      vecs[5] = mkv(1'b0, 8'h7F, 23'h000000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      vecs[6] = mkv(1'b0, 8'h44, 23'h0000FF, 1'b1, 1'b1, 1'b0, 32'h7F800000, 3'b011);
      vecs[7] = mkv(1'b1, 8'h01, 23'h000001, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 3'b101);
      vecs[8] = mkv(1'b0, 8'hFE, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b000);
      va = mkv(1'b0, 8'h01, 23'h000001, 1'b0, 1'b0, 1'b0, 32'h00800001, 3'b000);
      vb = mkv(1'b0, 8'h02, 23'h000002, 1'b0, 1'b0, 1'b0, 32'h01000002, 3'b000);
      vc = mkv(1'b1, 8'h03, 23'h000003, 1'b0, 1'b0, 1'b0, 32'h81800003, 3'b000);

      drive_sp(va, 1'b0);
      drive_dp(1'b0, 11'd0, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      sp_if.out_ready = 1'b0;
      dp_if.out_ready = 1'b0;

      #12;
      chk("rst_out_valid", 64'(sp_if.out_valid), 64'd0);
      chk("rst_in_ready",  64'(sp_if.in_ready),  64'd1);
      chk("rst_result",    64'(sp_if.out_result), 64'd0);
      chk("rst_flags",     64'(sp_if.out_flags),  64'd0);
`ifdef FP_STICKY_FLAGS_EN
      chk("rst_sticky",    64'(sp_sticky), 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Back-to-back stream with out_ready high: one result per cycle.
      sp_if.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_sp(vecs[i], 1'b1);
         tick();
         chk($sformatf("vec%0d_valid", i),  64'(sp_if.out_valid),  64'd1);
         chk($sformatf("vec%0d_result", i), 64'(sp_if.out_result), 64'(vecs[i].res));
         chk($sformatf("vec%0d_flags", i),  64'(sp_if.out_flags),  64'(vecs[i].flg));
      end
      sp_if.in_valid = 1'b0;
      tick();
      chk("drain_valid", 64'(sp_if.out_valid), 64'd0);

      // Backpressure: A and B fill the buffer, C waits until release.
      sp_if.out_ready = 1'b0;
      drive_sp(va, 1'b1);
      tick();
      chk("bp_a_ready",  64'(sp_if.in_ready),   64'd1);
      chk("bp_a_result", 64'(sp_if.out_result), 64'(va.res));
      drive_sp(vb, 1'b1);
      tick();
      chk("bp_full_ready", 64'(sp_if.in_ready),   64'd0);
      chk("bp_hold_a",     64'(sp_if.out_result), 64'(va.res));
      drive_sp(vc, 1'b1);
      tick();
      chk("bp_c_blocked", 64'(sp_if.in_ready),   64'd0);
      chk("bp_hold_a2",   64'(sp_if.out_result), 64'(va.res));
      chk("bp_hold_valid", 64'(sp_if.out_valid), 64'd1);
      sp_if.out_ready = 1'b1;
      tick();
      chk("bp_b_out",   64'(sp_if.out_result), 64'(vb.res));
      chk("bp_b_ready", 64'(sp_if.in_ready),   64'd1);
      tick();
      chk("bp_c_out",   64'(sp_if.out_result), 64'(vc.res));
      chk("bp_c_valid", 64'(sp_if.out_valid),  64'd1);
      sp_if.in_valid = 1'b0;
      tick();
      chk("bp_empty", 64'(sp_if.out_valid), 64'd0);

      // Reset while FULL discards both entries immediately.
      sp_if.out_ready = 1'b0;
      drive_sp(va, 1'b1);
      tick();
      drive_sp(vb, 1'b1);
      tick();
      chk("mr_full", 64'(sp_if.in_ready), 64'd0);
      sp_if.in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 64'(sp_if.out_valid),  64'd0);
      chk("mr_in_ready",  64'(sp_if.in_ready),   64'd1);
      chk("mr_result",    64'(sp_if.out_result), 64'd0);
      #2 rst_n = 1'b1;
      tick();
      sp_if.out_ready = 1'b1;
      tick();
      chk("mr_no_output", 64'(sp_if.out_valid), 64'd0);

      // Double precision special values and a plain pack.
      dp_if.out_ready = 1'b1;
      drive_dp(1'b0, 11'h012, 52'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("dp_inf",   64'(dp_if.out_result), 64'h7FF0000000000000);
      chk("dp_inf_f", 64'(dp_if.out_flags),  64'd2);
      drive_dp(1'b1, 11'h012, 52'h1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("dp_qnan", 64'(dp_if.out_result), 64'h7FF8000000000000);
      drive_dp(1'b1, 11'h3FF, 52'h8000000000000, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("dp_plain", 64'(dp_if.out_result), 64'hBFF8000000000000);
      dp_if.in_valid = 1'b0;
      tick();
      chk("dp_drain", 64'(dp_if.out_valid), 64'd0);

`ifdef FP_STICKY_FLAGS_EN
      // Sticky accumulation, clear, and clear coinciding with a transfer.
      drive_sp(vecs[1], 1'b1);
      tick();
      drive_sp(vecs[4], 1'b1);
      tick();
      sp_if.in_valid = 1'b0;
      tick();
      chk("sticky_acc", 64'(sp_sticky), 64'd3);
      sp_clr = 1'b1;
      tick();
      sp_clr = 1'b0;
      chk("sticky_clr", 64'(sp_sticky), 64'd0);
      drive_sp(vecs[2], 1'b1);
      tick();
      sp_if.in_valid = 1'b0;
      tick();
      chk("sticky_ovf", 64'(sp_sticky), 64'd2);
      drive_sp(vecs[3], 1'b1);
      tick();
      sp_if.in_valid = 1'b0;
      sp_clr = 1'b1;
      tick();
      sp_clr = 1'b0;
      chk("sticky_clr_xfer", 64'(sp_sticky), 64'd6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
Parametrised, pipelined final stage of the floating-point datapath. It takes the rounded sign, exponent and mantissa plus the exception indications from the rounding stage and packs them into an IEEE-754-style word. It resolves special values (NaN, infinity, signed zero), emits per-result exception flags, and decouples upstream from downstream with a valid/ready handshake and a 2-entry skid buffer. It serves adder, multiplier and future divider pipelines at any precision.

Parameters:
EXP_W, 8, exponent field width (8 = single, 11 = double)
MAN_W, 23, stored mantissa width (23 = single, 52 = double)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream operand valid
in_ready  out  1  packer can accept this cycle
in_sign  in  1  result sign
in_exp  in  EXP_W  rounded exponent
in_man  in  MAN_W  rounded mantissa
in_overflow  in  1  exponent overflow after rounding
in_underflow  in  1  result too small / flushed
in_invalid  in  1  NaN result required
out_valid  out  1  packed result valid
out_ready  in  1  downstream accepts
out_result  out  1+EXP_W+MAN_W  packed {sign, exp, man}
out_flags  out  3  {invalid, overflow, underflow} for this result
(with FP_STICKY_FLAGS_EN) flags_clr  in  1 ; sticky_flags  out  3

Behaviour:
- One clock domain on clk. Reset is asynchronous, active-low on rst_n. Reset clears both buffer entries: out_valid=0, out_result=0, out_flags=0, in_ready=1, sticky_flags=0.
- Packing priority, combinational before the register:
  - invalid: sign=0, exp=all ones, man=MSB 1 with rest 0 (quiet NaN).
  - else overflow: {sign, all ones, 0} (signed infinity).
  - else underflow: {sign, 0, 0} (signed zero).
  - else {sign, in_exp, in_man} unchanged.
- out_flags are the three raw inputs as captured, not the priority-reduced inputs.
- Transfer occurs on valid&&ready at each side.
- Latency: an accepted input appears on out_* on the next cycle when the buffer is empty. Throughput is 1 per cycle while out_ready=1.
- Buffer holds 2 entries: a main output register and a skid register. Occupancy states are EMPTY, ONE and FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop -> ONE, new data moves to the main register.
  - FULL: pop -> ONE, skid moves to the main register. No accept is possible in FULL.
- in_ready is registered and equals (state != FULL). It never depends combinationally on out_ready.
- out_result and out_flags are held stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO. No result is dropped or duplicated.
- Inputs are ignored when in_valid=0 or in_ready=0.
- Reset mid-transfer discards buffered results. No partial output is produced.

Optional Feature:
FP_STICKY_FLAGS_EN
- Defined: adds ports flags_clr and sticky_flags.
  - sticky_flags ORs in out_flags on every output transfer (out_valid&&out_ready).
  - flags_clr=1 clears the register the next cycle.
  - If a clear coincides with a transfer, the transfer's flags are kept and the old flags are cleared.
- Undefined: the ports and register are absent. Per-result out_flags are unchanged.

Decomposition:
- Shared package fp_pkg holds:
  - width constants: SP_EXP_W=8, SP_MAN_W=23, DP_EXP_W=11, DP_MAN_W=52
  - flag index constants FLG_INV=2, FLG_OVF=1, FLG_UNF=0
  - quiet-NaN mantissa pattern function
- One sub-module, fp_skid_buffer, handles generic-width 2-entry valid/ready buffering. The packer instantiates it with width 1+EXP_W+MAN_W+3.

Test Plan:
1. Defaults, sign=1, exp=0x80, man=0x400000, flags 0, out_ready=1 -> next cycle out_result=0xC0400000, out_flags=3'b000.
2. in_overflow=1, sign=0, exp=0x12 -> 0x7F800000, flags=3'b010. Same with sign=1 -> 0xFF800000.
3. in_invalid=1 together with in_overflow=1, sign=1 -> 0x7FC00000, flags=3'b110. in_underflow=1, sign=1 -> 0x80000000, flags=3'b001.
4. Backpressure: out_ready=0, offer A, B, C back-to-back -> A and B accepted, in_ready=0 the cycle after B, C held. Raise out_ready -> A, B, C delivered in order, no gaps after release.
5. EXP_W=11, MAN_W=52, overflow sign=0 -> 0x7FF0000000000000. Invalid -> 0x7FF8000000000000.
6. Buffer FULL, assert rst_n=0 mid-cycle -> out_valid=0 immediately, in_ready=1. With FP_STICKY_FLAGS_EN, overflow then underflow results -> sticky_flags=3'b011; flags_clr -> 3'b000.
